// File: rtl/uart_tx_if.sv
// Valid/ready word handshake between a parallel data source and the UART transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional even parity,
// STOP_BITS stop bits. Every output comes straight from a flop.
module uart_tx #(
  parameter int BAUD_DIV      = 434,
  parameter int DATA_BITS     = 8,
  parameter int ENABLE_PARITY = 1,
  parameter int STOP_BITS     = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus,
  output logic     tx_o,
  output logic     busy_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int            BW        = $clog2(DATA_BITS) + 1;
  localparam logic [15:0]   BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  state_e               state_q, state_d;
  logic [15:0]          baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 boundary;

  assign boundary     = (baud_q == BAUD_LAST);
  assign bus.tx_ready = ready_q;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  // tx_d is the level for the next bit, so each bit boundary loads the following bit.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    ready_d  = ready_q;

    case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        baud_d  = '0;
        bit_d   = '0;
        if (bus.tx_valid && ready_q) begin
          shift_d  = bus.tx_data;
          parity_d = ^bus.tx_data;
          tx_d     = 1'b0;
          ready_d  = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (boundary) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (boundary) begin
          baud_d = '0;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
            if (ENABLE_PARITY != 0) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      PARITY: begin
        if (boundary) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (boundary) begin
          baud_d = '0;
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase

    busy_d = ~ready_d;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no parity / parity / parity with two stop bits)
// checked cycle by cycle against frames built from the transmitted word.
module tb_uart_tx;
  localparam int BAUD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] dataDrv  [3];
  logic       validDrv [3];
  logic [2:0] txBus, busyBus, readyBus;

  int cfgParity [3] = '{0, 1, 1};
  int cfgStops  [3] = '{1, 1, 2};

  uart_tx_if #(.DATA_BITS(8)) ifA ();
  uart_tx_if #(.DATA_BITS(8)) ifB ();
  uart_tx_if #(.DATA_BITS(8)) ifC ();

  assign ifA.tx_data  = dataDrv[0];
  assign ifA.tx_valid = validDrv[0];
  assign readyBus[0]  = ifA.tx_ready;
  assign ifB.tx_data  = dataDrv[1];
  assign ifB.tx_valid = validDrv[1];
  assign readyBus[1]  = ifB.tx_ready;
  assign ifC.tx_data  = dataDrv[2];
  assign ifC.tx_valid = validDrv[2];
  assign readyBus[2]  = ifC.tx_ready;

  uart_tx #(.BAUD_DIV(BAUD), .DATA_BITS(8), .ENABLE_PARITY(0), .STOP_BITS(1)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(ifA), .tx_o(txBus[0]), .busy_o(busyBus[0]));
  uart_tx #(.BAUD_DIV(BAUD), .DATA_BITS(8), .ENABLE_PARITY(1), .STOP_BITS(1)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(ifB), .tx_o(txBus[1]), .busy_o(busyBus[1]));
  uart_tx #(.BAUD_DIV(BAUD), .DATA_BITS(8), .ENABLE_PARITY(1), .STOP_BITS(2)) dutC (
    .clk(clk), .rst_n(rst_n), .bus(ifC), .tx_o(txBus[2]), .busy_o(busyBus[2]));

  typedef struct {
    logic [15:0] bits;
    int          nBits;
  } frame_t;

  typedef struct {
    int         cfg;
    logic [7:0] data;
    logic       expPar;
    int         expLen;
  } vec_t;

  frame_t sbQ[$];
  int checks = 0;
  int errors = 0;

  function automatic frame_t buildFrame(int cfg, logic [7:0] d, logic par);
    frame_t f;
    f.bits  = '0;
    f.bits[0] = 1'b0;
    f.nBits = 1;
    for (int i = 0; i < 8; i++) begin
      f.bits[f.nBits] = d[i];
      f.nBits++;
    end
    if (cfgParity[cfg] != 0) begin
      f.bits[f.nBits] = par;
      f.nBits++;
    end
    for (int s = 0; s < cfgStops[cfg]; s++) begin
      f.bits[f.nBits] = 1'b1;
      f.nBits++;
    end
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Queue the expected frame, then present the word once the DUT is ready.
  task automatic applyStimulus(input int cfg, input logic [7:0] d, input logic par,
                               input bit keepValid, input logic [7:0] nextData);
    bit seen = 1'b0;
    sbQ.push_back(buildFrame(cfg, d, par));
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (readyBus[cfg] === 1'b1) seen = 1'b1;
    end
    if (!seen) checkOutput("readyTimeout", 16'd0, 16'd1);
    dataDrv[cfg]  = d;
    validDrv[cfg] = 1'b1;
    @(posedge clk);
    #1;
    validDrv[cfg] = keepValid;
    dataDrv[cfg]  = nextData;
  endtask

  // Called #1 after the accepting edge; cycle k of the frame is sampled at the k-th negedge.
  task automatic checkFrame(input int cfg, input int expLen, input string name);
    frame_t f;
    logic   seenBit [16];
    bit     badBit  [16];
    bit     readyLow = 1'b1;
    int     b;
    if (sbQ.size() == 0) begin
      checkOutput({name, "_sbEmpty"}, 16'd0, 16'd1);
      return;
    end
    f = sbQ.pop_front();
    for (int i = 0; i < 16; i++) begin
      badBit[i]  = 1'b0;
      seenBit[i] = f.bits[i];
    end
    for (int k = 0; k < expLen; k++) begin
      @(negedge clk);
      b = k / BAUD;
      if (b < 16 && txBus[cfg] !== f.bits[b]) begin
        badBit[b]  = 1'b1;
        seenBit[b] = txBus[cfg];
      end
      if (readyBus[cfg] !== 1'b0 || busyBus[cfg] !== 1'b1) readyLow = 1'b0;
    end
    for (int i = 0; i < f.nBits; i++)
      checkOutput($sformatf("%s_bit%0d", name, i), 16'(seenBit[i]), 16'(f.bits[i]));
    checkOutput({name, "_readyLowDuringFrame"}, 16'(readyLow), 16'd1);
    @(negedge clk);
    checkOutput({name, "_readyAtEnd"}, 16'(readyBus[cfg]), 16'd1);
    checkOutput({name, "_busyAtEnd"}, 16'(busyBus[cfg]), 16'd0);
    checkOutput({name, "_txIdleAtEnd"}, 16'(txBus[cfg]), 16'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs [8];
    vecs[0] = '{0, 8'h55, 1'b0, 40};
    vecs[1] = '{1, 8'h07, 1'b1, 44};
    vecs[2] = '{1, 8'h03, 1'b0, 44};
    vecs[3] = '{0, 8'h00, 1'b0, 40};
    vecs[4] = '{1, 8'hFF, 1'b0, 44};
    vecs[5] = '{1, 8'hA5, 1'b0, 44};
    vecs[6] = '{2, 8'h3C, 1'b0, 48};
    vecs[7] = '{2, 8'h81, 1'b0, 48};

    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      dataDrv[c]  = 8'h00;
      validDrv[c] = 1'b0;
    end
    #22;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("reset_tx%0d", c), 16'(txBus[c]), 16'd1);
      checkOutput($sformatf("reset_ready%0d", c), 16'(readyBus[c]), 16'd1);
      checkOutput($sformatf("reset_busy%0d", c), 16'(busyBus[c]), 16'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].cfg, vecs[i].data, vecs[i].expPar, 1'b0, 8'($urandom));
      checkFrame(vecs[i].cfg, vecs[i].expLen, $sformatf("vec%0d", i));
    end

    // Back-to-back: valid stays high, second word waits on tx_data through the first frame.
    applyStimulus(1, 8'hC3, 1'b0, 1'b1, 8'h5A);
    sbQ.push_back(buildFrame(1, 8'h5A, 1'b0));
    checkFrame(1, 44, "b2bFirst");
    @(posedge clk);
    #1;
    validDrv[1] = 1'b0;
    dataDrv[1]  = 8'hA5;
    checkFrame(1, 44, "b2bSecond");

    // Reset during data bit 3 (cycles 16..19), then a clean frame afterwards.
    applyStimulus(0, 8'hF0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 18; k++) @(negedge clk);
    checkOutput("midFrame_txLow", 16'(txBus[0]), 16'd0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncReset_tx", 16'(txBus[0]), 16'd1);
    checkOutput("asyncReset_ready", 16'(readyBus[0]), 16'd1);
    checkOutput("asyncReset_busy", 16'(busyBus[0]), 16'd0);
    void'(sbQ.pop_back());
    dataDrv[0]  = 8'h81;
    validDrv[0] = 1'b1;
    sbQ.push_back(buildFrame(0, 8'h81, 1'b0));
    @(posedge clk);
    #1;
    checkOutput("heldReset_tx", 16'(txBus[0]), 16'd1);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    validDrv[0] = 1'b0;
    dataDrv[0]  = 8'h7E;
    checkFrame(0, 40, "postReset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
